// File: rtl/gcd_batch_driver.sv
// Batch initiator for the GCD core Start/Ack handshake.
// Replays a 4-entry operand table and records GCD and wait cycles per entry.
module gcd_batch_driver #(
    parameter int TIMEOUT = 200
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Load,
    input  logic [1:0] LoadIdx,
    input  logic [7:0] LoadA,
    input  logic [7:0] LoadB,
    input  logic       Go,
    input  logic [1:0] LastIdx,
    input  logic [1:0] RdIdx,
    output logic [7:0] RdGCD,
    output logic [7:0] RdCycles,
    output logic       Start,
    output logic       Ack,
    output logic [7:0] Ain,
    output logic [7:0] Bin,
    input  logic       q_Done,
    input  logic [7:0] AB_GCD,
    output logic       Busy,
    output logic       BatchDone,
    output logic       Err
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        ISSUE = 6'b000010,
        WAIT  = 6'b000100,
        ACK   = 6'b001000,
        NEXT  = 6'b010000,
        FIN   = 6'b100000
    } state_t;

    state_t     state;
    logic [1:0] idx;
    logic [1:0] last;
    logic [7:0] cnt;
    logic [7:0] op_a [4];
    logic [7:0] op_b [4];
    logic [7:0] res_gcd [4];
    logic [7:0] res_cyc [4];

    logic [7:0] cnt_next;
    logic [1:0] idx_next;
    logic       byp0;

    assign cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign idx_next = idx + 2'd1;
    // A Load to entry 0 on the Go edge must reach the first issue.
    assign byp0     = Load && (LoadIdx == 2'd0);

    assign RdGCD    = res_gcd[RdIdx];
    assign RdCycles = res_cyc[RdIdx];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            Start     <= 1'b0;
            Ack       <= 1'b0;
            Ain       <= 8'd0;
            Bin       <= 8'd0;
            Busy      <= 1'b0;
            BatchDone <= 1'b0;
            Err       <= 1'b0;
            idx       <= 2'd0;
            last      <= 2'd0;
            cnt       <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                op_a[i]    <= 8'd0;
                op_b[i]    <= 8'd0;
                res_gcd[i] <= 8'd0;
                res_cyc[i] <= 8'd0;
            end
        end else begin
            Start     <= 1'b0;
            Ack       <= 1'b0;
            BatchDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (Load) begin
                        op_a[LoadIdx] <= LoadA;
                        op_b[LoadIdx] <= LoadB;
                    end
                    if (Go) begin
                        idx   <= 2'd0;
                        last  <= LastIdx;
                        Err   <= 1'b0;
                        Ain   <= byp0 ? LoadA : op_a[0];
                        Bin   <= byp0 ? LoadB : op_b[0];
                        Start <= 1'b1;
                        Busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (q_Done) begin
                        res_gcd[idx] <= AB_GCD;
                        res_cyc[idx] <= cnt_next;
                        Ack          <= 1'b1;
                        state        <= ACK;
                    end else if (cnt_next >= TO) begin
                        res_gcd[idx] <= 8'd0;
                        res_cyc[idx] <= TO;
                        Err          <= 1'b1;
                        BatchDone    <= 1'b1;
                        state        <= FIN;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                ACK: begin
                    state <= NEXT;
                end
                NEXT: begin
                    if (idx == last) begin
                        BatchDone <= 1'b1;
                        state     <= FIN;
                    end else begin
                        idx   <= idx_next;
                        Ain   <= op_a[idx_next];
                        Bin   <= op_b[idx_next];
                        Start <= 1'b1;
                        state <= ISSUE;
                    end
                end
                FIN: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gcd_batch_driver.md
# gcd_batch_driver

Initiator for the GCD core's Start/Ack handshake. Holds a 4-entry operand table, and on Go issues each pair to the core in order. For each pair it waits for q_Done, captures AB_GCD and the wait-cycle count into a result table, then pulses Ack. It sits between the top-level board logic (switches/buttons, display readout) and the GCD core, replacing manual Start/Ack button presses.

## Interface
- TIMEOUT, 200: max cycles in WAIT before abort; legal range 1..255.
- Clk  in  1  system clock; all logic on posedge.
- Reset_n  in  1  synchronous, active-low reset.
- Load  in  1  write LoadA/LoadB into operand entry LoadIdx (IDLE only).
- LoadIdx  in  2  operand table write index.
- LoadA, LoadB  in  8  operand values.
- Go  in  1  start batch (IDLE only); LastIdx sampled on the same edge.
- LastIdx  in  2  batch processes entries 0..LastIdx.
- RdIdx  in  2  result table read index (combinational read).
- RdGCD  out  8  captured GCD for entry RdIdx.
- RdCycles  out  8  WAIT-cycle count for entry RdIdx.
- Start  out  1  to core; one-cycle pulse per issue.
- Ack  out  1  to core; one-cycle pulse per completion.
- Ain, Bin  out  8  to core operands; registered.
- q_Done  in  1  from core, DONE state indicator.
- AB_GCD  in  8  from core result.
- Busy  out  1  high in every state except IDLE.
- BatchDone  out  1  one-cycle pulse when a batch ends (normal or abort).
- Err  out  1  sticky timeout flag; cleared on accepted Go.

## Operation
- One-hot FSM, 6 states: IDLE, ISSUE, WAIT, ACK, NEXT, FIN.
- IDLE:
  - Load writes the operand table.
  - Go: set idx=0, latch LastIdx into last, clear Err, go to ISSUE.
  - Load and Go on the same edge: the write lands first; ISSUE reads the new value.
- ISSUE:
  - Ain/Bin <= table[idx], Start=1 for this cycle, wait counter cleared, go to WAIT.
  - The core samples Ain/Bin and Start on the same edge.
- WAIT:
  - Start=0; Ain/Bin held stable.
  - Counter increments each cycle, saturating at 255.
  - q_Done=1: RdGCD entry [idx] <= AB_GCD, cycle entry [idx] <= counter, go to ACK.
  - Counter reaches TIMEOUT with q_Done=0: result [idx] <= 0, cycles [idx] <= TIMEOUT, Err <= 1, go to FIN. No Ack is sent; the core is recovered by its own reset.
- ACK: Ack=1 for exactly one cycle, go to NEXT. The core returns to its initial state on this edge.
- NEXT:
  - idx == last: go to FIN.
  - Otherwise idx <= idx+1, go to ISSUE.
  - NEXT gives one idle cycle so the core is in its initial state before the next Start.
- FIN: BatchDone=1 for one cycle, go to IDLE.
- Busy states:
  - Load and Go are ignored in every state except IDLE.
  - A Go held high through FIN restarts only after IDLE is reached (level-sampled in IDLE).
- Operand table is not modified by a batch; re-Go replays the same pairs.
- Result table keeps entries beyond last from prior batches.
- Unreachable state encodings go to IDLE.

## Timing
- Reset_n=0 at an edge clears the following to 0: state=IDLE, Start, Ack, Ain, Bin, Busy, BatchDone, Err, idx, counter, all table and result entries.
- Reset mid-batch aborts immediately with no BatchDone.
- Go accepted at edge t:
  - Start is high in cycle t+1 (ISSUE).
  - WAIT starts at t+2.
- q_Done seen at edge w:
  - Ack is high in cycle w+1.
  - NEXT at w+2; next Start at w+3.
- Per-entry overhead is 4 cycles plus the core latency.
- Counter value recorded = number of WAIT cycles before q_Done was seen (minimum 1).
- RdGCD/RdCycles update the cycle after capture.

## Test plan
- Load (36,24),(17,5),(64,48),(9,9); Go with LastIdx=3 and the core at CEN=1.
  - Required: RdGCD = 12, 1, 16, 9.
  - Exactly 4 Start and 4 Ack pulses, then one BatchDone; Busy drops with it.
- Go with LastIdx=0 on (8,8):
  - Start in cycle t+1.
  - A single Ack.
  - BatchDone two cycles after Ack.
  - Entries 1..3 unchanged.
- Core stub holds q_Done=0, TIMEOUT=5:
  - Err=1 and BatchDone after 5 WAIT cycles.
  - Ack never asserted; RdGCD[0]=0, RdCycles[0]=5.
  - The next Go clears Err.
- During a batch, pulse Load (idx 1, value 99,33) and Go:
  - Both are ignored; the batch completes on the original data.
  - After IDLE, the same Load takes effect.
- Reset_n=0 for one cycle while in WAIT:
  - All outputs 0 next cycle and no BatchDone.
  - A subsequent Go runs correctly.
- Load and Go on the same edge for entry 0 = (100,75): RdGCD[0]=25.
